sipo_frame_ctrl: RTL and testbench

- Frame controller that sequences an internal sipo_reg instance.
- Accepts a serial bit stream over a valid/ready handshake and drives sipo_reg we/shift_dir/out_dir.
- Counts exactly DATA_WIDTH bits per frame, then stops shifting for the capture cycle.
- Presents the assembled word on a valid/ready output port; sits between a serial link front-end and the word-level consumer.

---
 rtl/sipo_frame_ctrl_pkg.sv | 18 +
 rtl/sipo_reg.sv | 44 ++++
 rtl/sipo_frame_ctrl.sv | 134 +++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared types and sizing helpers for the SIPO frame controller and its shift register.
package sipo_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int FRAME_CNT_W = 16;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sipo_reg.sv
// Serial-in parallel-out shift register with selectable shift direction and a
// registered, optionally bit-reversed, parallel output.
module sipo_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  we,
  input  logic                  shift_dir,
  input  logic                  out_dir,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] parallel_out
);

  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] par_p1;

  function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = v[DATA_WIDTH-1-i];
    return r;
  endfunction

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      shreg <= '0;
    end else if (we) begin
      shreg <= shift_dir ? {shreg[DATA_WIDTH-2:0], serial_in}
                         : {serial_in, shreg[DATA_WIDTH-1:1]};
    end
  end

  // Output stage: one register after the shift chain, loaded every cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      par_p1 <= '0;
    end else begin
      par_p1 <= out_dir ? bit_rev(shreg) : shreg;
    end
  end

  assign parallel_out = par_p1;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: collects DATA_WIDTH serial bits into sipo_reg and presents the word
// on a valid/ready port. Optional inter-bit timeout under SIPO_FRAME_CTRL_TIMEOUT_EN.
module sipo_frame_ctrl
  import sipo_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   cfg_shift_dir,
  input  logic                   cfg_out_dir,
  input  logic                   flush,
  input  logic                   s_valid,
  input  logic                   s_data,
  output logic                   s_ready,
  output logic                   m_valid,
  output logic [DATA_WIDTH-1:0]  m_data,
  input  logic                   m_ready,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   err_timeout
);

  localparam int BCW = cnt_w(DATA_WIDTH);

  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("sipo_frame_ctrl: DATA_WIDTH must be 2 or more");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("sipo_frame_ctrl: TIMEOUT_CYCLES must be 1 or more");
  end

  state_t                state;
  logic [BCW-1:0]        bit_cnt;
  logic                  shift_dir_q;
  logic                  out_dir_q;
  logic                  acc;
  logic                  last_bit;
  logic                  timeout_hit;
  logic                  sipo_shift_dir;
  logic                  sipo_out_dir;
  logic [DATA_WIDTH-1:0] par_data;

  // s_ready is held low while reset is asserted so nothing is taken during reset.
  assign s_ready  = arst_n & ~flush & ((state == IDLE) | (state == SHIFT));
  assign acc      = s_valid & s_ready;
  assign last_bit = (bit_cnt == BCW'(DATA_WIDTH - 1));
  assign busy     = (state != IDLE);
  assign m_valid  = (state == HOLD);
  assign m_data   = m_valid ? par_data : '0;

  assign sipo_shift_dir = (state == IDLE) ? cfg_shift_dir : shift_dir_q;
  assign sipo_out_dir   = (state == IDLE) ? cfg_out_dir   : out_dir_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_dir_q <= 1'b0;
      out_dir_q   <= 1'b0;
      frame_cnt   <= '0;
    end else if (flush) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          shift_dir_q <= cfg_shift_dir;
          out_dir_q   <= cfg_out_dir;
          bit_cnt     <= BCW'(1);
          state       <= SHIFT;
        end
        SHIFT: if (timeout_hit) begin
          state   <= IDLE;
          bit_cnt <= '0;
        end else if (acc) begin
          bit_cnt <= bit_cnt + BCW'(1);
          if (last_bit) state <= CAPTURE;
        end
        CAPTURE: state <= HOLD;
        HOLD: if (m_ready) begin
          state     <= IDLE;
          bit_cnt   <= '0;
          frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SIPO_FRAME_CTRL_TIMEOUT_EN
  localparam int TCW = cnt_w(TIMEOUT_CYCLES);

  logic [TCW-1:0] idle_cnt;
  logic           err_q;

  // idle_cnt counts consecutive SHIFT cycles without an accepted bit.
  assign timeout_hit = (state == SHIFT) & ~flush & ~acc &
                       (idle_cnt == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      idle_cnt <= '0;
      err_q    <= 1'b0;
    end else if (flush) begin
      idle_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state != SHIFT) || acc || timeout_hit) idle_cnt <= '0;
      else                                        idle_cnt <= idle_cnt + TCW'(1);
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  sipo_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sipo_reg (
    .clk          (clk),
    .arst_n       (arst_n),
    .we           (acc),
    .shift_dir    (sipo_shift_dir),
    .out_dir      (sipo_out_dir),
    .serial_in    (s_data),
    .parallel_out (par_data)
  );

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed self-checking bench for sipo_frame_ctrl with DATA_WIDTH = 8.
// Timeout steps apply when built with SIPO_FRAME_CTRL_TIMEOUT_EN.
module tb_sipo_frame_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         cfg_shift_dir;
  logic         cfg_out_dir;
  logic         flush;
  logic         s_valid;
  logic         s_data;
  logic         s_ready;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_ready;
  logic         busy;
  logic [15:0]  frame_cnt;
  logic         err_timeout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(
    .DATA_WIDTH     (W),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .cfg_shift_dir (cfg_shift_dir),
    .cfg_out_dir   (cfg_out_dir),
    .flush         (flush),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .busy          (busy),
    .frame_cnt     (frame_cnt),
    .err_timeout   (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one full frame back-to-back (first bit = bits[7]) and stops in HOLD.
  task automatic run_frame(input logic [7:0] bits, input logic sd, input logic od,
                           input logic [7:0] exp);
    cfg_shift_dir = sd;
    cfg_out_dir   = od;
    for (int i = 0; i < W; i++) begin
      s_valid = 1'b1;
      s_data  = bits[7-i];
      #1;
      check("shift_s_ready", 32'(s_ready), 32'd1);
      check("shift_m_valid", 32'(m_valid), 32'd0);
      step();
    end
    s_valid = 1'b0;
    s_data  = 1'b0;
    #1;
    check("capture_s_ready", 32'(s_ready), 32'd0);
    check("capture_m_valid", 32'(m_valid), 32'd0);
    check("capture_busy",    32'(busy),    32'd1);
    step();
    check("hold_m_valid", 32'(m_valid), 32'd1);
    check("hold_m_data",  32'(m_data),  32'(exp));
    check("hold_s_ready", 32'(s_ready), 32'd0);
  endtask

  task automatic handshake(input logic [15:0] exp_cnt);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("post_hs_m_valid",   32'(m_valid),   32'd0);
    check("post_hs_m_data",    32'(m_data),    32'd0);
    check("post_hs_busy",      32'(busy),      32'd0);
    check("post_hs_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n        = 1'b0;
    cfg_shift_dir = 1'b0;
    cfg_out_dir   = 1'b0;
    flush         = 1'b0;
    s_valid       = 1'b0;
    s_data        = 1'b0;
    m_ready       = 1'b0;
    #2;
    check("rst_s_ready",   32'(s_ready),     32'd0);
    check("rst_m_valid",   32'(m_valid),     32'd0);
    check("rst_m_data",    32'(m_data),      32'd0);
    check("rst_busy",      32'(busy),        32'd0);
    check("rst_frame_cnt", 32'(frame_cnt),   32'd0);
    check("rst_err",       32'(err_timeout), 32'd0);
    step();
    step();
    arst_n = 1'b1;
    #1;
    check("idle_s_ready", 32'(s_ready), 32'd1);
    step();

    // Four direction combinations on the same bit stream.
    run_frame(8'b1011_0010, 1'b1, 1'b0, 8'hB2);
    handshake(16'd1);
    run_frame(8'b1011_0010, 1'b1, 1'b1, 8'h4D);
    handshake(16'd2);
    run_frame(8'b1011_0010, 1'b0, 1'b0, 8'h4D);
    handshake(16'd3);
    run_frame(8'b1011_0010, 1'b0, 1'b1, 8'hB2);
    handshake(16'd4);

    // Backpressure in HOLD.
    run_frame(8'b1011_0010, 1'b1, 1'b0, 8'hB2);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_m_valid",   32'(m_valid),   32'd1);
      check("bp_m_data",    32'(m_data),    32'hB2);
      check("bp_s_ready",   32'(s_ready),   32'd0);
      check("bp_frame_cnt", 32'(frame_cnt), 32'd4);
    end
    handshake(16'd5);

    // Flush after three accepted bits, then a clean frame.
    cfg_shift_dir = 1'b1;
    cfg_out_dir   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 1'b1;
      step();
    end
    flush = 1'b1;
    #1;
    check("flush_s_ready", 32'(s_ready), 32'd0);
    step();
    flush   = 1'b0;
    s_valid = 1'b0;
    check("flush_busy",      32'(busy),      32'd0);
    check("flush_frame_cnt", 32'(frame_cnt), 32'd5);
    run_frame(8'b1010_0101, 1'b1, 1'b0, 8'hA5);
    handshake(16'd6);
    check("flush_one_word", 32'(m_valid), 32'd0);

    // Flush discards a word sitting in HOLD.
    run_frame(8'b1100_0011, 1'b1, 1'b0, 8'hC3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("hold_flush_m_valid",   32'(m_valid),   32'd0);
    check("hold_flush_m_data",    32'(m_data),    32'd0);
    check("hold_flush_frame_cnt", 32'(frame_cnt), 32'd6);

    // Asynchronous reset while in HOLD.
    run_frame(8'b1011_0010, 1'b1, 1'b0, 8'hB2);
    arst_n = 1'b0;
    #1;
    check("arst_m_valid",   32'(m_valid),   32'd0);
    check("arst_m_data",    32'(m_data),    32'd0);
    check("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    step();
    arst_n = 1'b1;
    step();
    run_frame(8'hFF, 1'b1, 1'b0, 8'hFF);
    handshake(16'd1);

`ifdef SIPO_FRAME_CTRL_TIMEOUT_EN
    // Three bits then four idle cycles with TIMEOUT_CYCLES = 4.
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 1'b0;
      step();
    end
    s_valid = 1'b0;
    step();
    step();
    step();
    check("to_busy_before",  32'(busy),        32'd1);
    check("to_err_before",   32'(err_timeout), 32'd0);
    step();
    check("to_busy_after",   32'(busy),        32'd0);
    check("to_err_after",    32'(err_timeout), 32'd1);
    check("to_m_valid",      32'(m_valid),     32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("to_err_cleared",  32'(err_timeout), 32'd0);
`else
    // Without the timeout feature SHIFT waits indefinitely.
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 1'b0;
      step();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("nto_busy",  32'(busy),        32'd1);
    check("nto_err",   32'(err_timeout), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("nto_flush_busy", 32'(busy), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
